// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial arithmetic units.
// State encoding and counter sizing helper.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - b_in.
// Purely combinational; borrow ripples through a flop in the parent.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  assign d     = a ^ b ^ b_in;
  assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock.
// start/done handshake; results held until the next DONE.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  import serial_arith_pkg::*;

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             a_msb;
  logic             b_msb;
  logic             d;
  logic             br_nxt;
  logic             last;
  logic             load;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .b_in (br),
    .d    (d),
    .b_out(br_nxt)
  );

  assign last = (cnt == CW'(WIDTH - 1));
  assign load = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res        <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: state <= IDLE;
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          res  <= {d, res[WIDTH-1:1]};
          br   <= br_nxt;
          cnt  <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          done       <= 1'b1;
          diff       <= res;
          borrow_out <= br;
          overflow   <= (a_msb != b_msb) && (res[WIDTH-1] != a_msb);
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // a new start overrides the IDLE/DONE next-state choice
      if (load) begin
        a_sr  <= a;
        b_sr  <= b;
        br    <= 1'b0;
        cnt   <= '0;
        a_msb <= a[WIDTH-1];
        b_msb <= b[WIDTH-1];
        busy  <= 1'b1;
        state <= SHIFT;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor.
// Transaction-level model plus directed literal cases.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  int checks = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow_out(borrow_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Transaction model: a job accepted at edge 0 is in flight for
  // W shift edges, then reports at edge W+1.
  bit           m_active = 0;
  int           m_t = 0;
  logic [W-1:0] p_diff = '0;
  logic         p_bor = 0;
  logic         p_ovf = 0;
  logic [W-1:0] m_diff = '0;
  logic         m_bor = 0;
  logic         m_ovf = 0;
  logic         m_done = 0;
  logic         m_busy;

  assign m_busy = m_active && (m_t < W);

  always @(posedge clk or negedge rst_n) begin : model
    int s;
    if (!rst_n) begin
      m_active = 0; m_t = 0; m_done = 0;
      m_diff = '0; m_bor = 0; m_ovf = 0;
    end else begin
      m_done = 0;
      if (m_active) begin
        if (m_t == W) begin
          m_done = 1;
          m_diff = p_diff;
          m_bor  = p_bor;
          m_ovf  = p_ovf;
          m_active = 0;
        end else begin
          m_t++;
        end
      end
      if (start && !m_active) begin
        p_diff = a - b;
        p_bor  = (a < b);
        s = int'($signed(a)) - int'($signed(b));
        p_ovf  = (s > (2**(W-1) - 1)) || (s < -(2**(W-1)));
        m_active = 1;
        m_t = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("diff", diff, m_diff);
    chk("borrow", borrow_out, m_bor);
    chk("ovf", overflow, m_ovf);
  end

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic [W-1:0] ed, input logic eb,
                    input logic eo, input string nm);
    int cyc;
    int bc;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    bc = 0;
    while (1) begin
      if (busy) bc++;
      if (done || cyc >= 30) break;
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_lat"}, cyc, W + 2);
    chk({nm, "_busycyc"}, bc, W);
    chk({nm, "_diff"}, diff, ed);
    chk({nm, "_bor"}, borrow_out, eb);
    chk({nm, "_ovf"}, overflow, eo);
  endtask

  initial begin
    int dones;
    int k;
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bor", borrow_out, 0);
    chk("rst_ovf", overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op(8'd5, 8'd3, 8'h02, 1'b0, 1'b0, "t1");
    op(8'd3, 8'd5, 8'hFE, 1'b1, 1'b0, "t2");
    op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "t3a");
    op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "t3b");
    op(8'h22, 8'h00, 8'h22, 1'b0, 1'b0, "bzero");
    op(8'hC3, 8'hC3, 8'h00, 1'b0, 1'b0, "aeqb");

    // start pulsed mid-shift must be ignored
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        chk("t4_diff", diff, 8'h0F);
      end
    end
    chk("t4_dones", dones, 1);

    // back-to-back: start held through DONE
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    @(negedge clk);
    a = 8'h00; b = 8'h01;
    k = 1;
    while (!done && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("t5_first", diff, 8'h0F);
    start = 1'b0;
    k = 0;
    while (k < 30) begin
      @(negedge clk);
      k++;
      if (done) break;
      chk("t5_hold", diff, 8'h0F);
    end
    chk("t5_gap", k, W + 1);
    chk("t5_diff", diff, 8'hFF);
    chk("t5_bor", borrow_out, 1'b1);
    chk("t5_ovf", overflow, 1'b0);

    // asynchronous reset in the middle of a shift
    @(negedge clk);
    a = 8'd5; b = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_diff", diff, 0);
    chk("t6_bor", borrow_out, 0);
    chk("t6_ovf", overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    op(8'hAA, 8'h55, 8'h55, 1'b0, 1'b1, "t6_after");

    // random traffic, including back-to-back and ignored starts
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rx = W'($urandom);
      ry = W'($urandom);
      a = rx;
      b = ry;
      start = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
